// File: rtl/axi_arb_pkg.sv
// rtl/axi_arb_pkg.sv - shared FSM state types and constants for the two-master AXI3 arbiter
package axi_arb_pkg;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_ADDR,
    WR_DATA,
    WR_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ADDR,
    RD_DATA
  } rd_state_t;

  localparam logic       ARB_M0    = 1'b0;
  localparam logic       ARB_M1    = 1'b1;
  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - 2-way round-robin picker holding the latched grant and the preference pointer
module rr_arb2
  import axi_arb_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       load,
  input  logic       advance,
  output logic       grant,
  output logic       pointer
);

  logic pick;

  // A lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    case (req)
      2'b01:   pick = ARB_M0;
      2'b10:   pick = ARB_M1;
      default: pick = pointer;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      grant   <= ARB_M0;
      pointer <= ARB_M0;
    end else begin
      if (load) begin
        grant <= pick;
      end
      if (advance) begin
        pointer <= ~grant;
      end
    end
  end

endmodule

// File: rtl/axi_2m_arbiter.sv
// rtl/axi_2m_arbiter.sv - two-master AXI3 arbiter, independent single-outstanding read and write paths
module axi_2m_arbiter
  import axi_arb_pkg::*;
#(
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 64,
  parameter  int MID_WIDTH  = 4,
  localparam int STRB_WIDTH = DATA_WIDTH / 8,
  localparam int SID_WIDTH  = MID_WIDTH + 1
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  // master 0
  input  logic                  M0_AWVALID,
  input  logic [ADDR_WIDTH-1:0] M0_AWADDR,
  input  logic [3:0]            M0_AWLEN,
  input  logic [2:0]            M0_AWSIZE,
  input  logic [1:0]            M0_AWBURST,
  input  logic [MID_WIDTH-1:0]  M0_AWID,
  output logic                  M0_AWREADY,
  input  logic                  M0_WVALID,
  input  logic [DATA_WIDTH-1:0] M0_WDATA,
  input  logic [STRB_WIDTH-1:0] M0_WSTRB,
  input  logic                  M0_WLAST,
  output logic                  M0_WREADY,
  output logic                  M0_BVALID,
  output logic [MID_WIDTH-1:0]  M0_BID,
  output logic [1:0]            M0_BRESP,
  input  logic                  M0_BREADY,
  input  logic                  M0_ARVALID,
  input  logic [ADDR_WIDTH-1:0] M0_ARADDR,
  input  logic [3:0]            M0_ARLEN,
  input  logic [2:0]            M0_ARSIZE,
  input  logic [1:0]            M0_ARBURST,
  input  logic [MID_WIDTH-1:0]  M0_ARID,
  output logic                  M0_ARREADY,
  output logic                  M0_RVALID,
  output logic [DATA_WIDTH-1:0] M0_RDATA,
  output logic [MID_WIDTH-1:0]  M0_RID,
  output logic [1:0]            M0_RRESP,
  output logic                  M0_RLAST,
  input  logic                  M0_RREADY,
  // master 1
  input  logic                  M1_AWVALID,
  input  logic [ADDR_WIDTH-1:0] M1_AWADDR,
  input  logic [3:0]            M1_AWLEN,
  input  logic [2:0]            M1_AWSIZE,
  input  logic [1:0]            M1_AWBURST,
  input  logic [MID_WIDTH-1:0]  M1_AWID,
  output logic                  M1_AWREADY,
  input  logic                  M1_WVALID,
  input  logic [DATA_WIDTH-1:0] M1_WDATA,
  input  logic [STRB_WIDTH-1:0] M1_WSTRB,
  input  logic                  M1_WLAST,
  output logic                  M1_WREADY,
  output logic                  M1_BVALID,
  output logic [MID_WIDTH-1:0]  M1_BID,
  output logic [1:0]            M1_BRESP,
  input  logic                  M1_BREADY,
  input  logic                  M1_ARVALID,
  input  logic [ADDR_WIDTH-1:0] M1_ARADDR,
  input  logic [3:0]            M1_ARLEN,
  input  logic [2:0]            M1_ARSIZE,
  input  logic [1:0]            M1_ARBURST,
  input  logic [MID_WIDTH-1:0]  M1_ARID,
  output logic                  M1_ARREADY,
  output logic                  M1_RVALID,
  output logic [DATA_WIDTH-1:0] M1_RDATA,
  output logic [MID_WIDTH-1:0]  M1_RID,
  output logic [1:0]            M1_RRESP,
  output logic                  M1_RLAST,
  input  logic                  M1_RREADY,
  // slave side toward the bridge
  output logic                  S_AWVALID,
  output logic [ADDR_WIDTH-1:0] S_AWADDR,
  output logic [3:0]            S_AWLEN,
  output logic [2:0]            S_AWSIZE,
  output logic [1:0]            S_AWBURST,
  output logic [SID_WIDTH-1:0]  S_AWID,
  input  logic                  S_AWREADY,
  output logic                  S_WVALID,
  output logic [DATA_WIDTH-1:0] S_WDATA,
  output logic [STRB_WIDTH-1:0] S_WSTRB,
  output logic                  S_WLAST,
  input  logic                  S_WREADY,
  input  logic                  S_BVALID,
  input  logic [SID_WIDTH-1:0]  S_BID,
  input  logic [1:0]            S_BRESP,
  output logic                  S_BREADY,
  output logic                  S_ARVALID,
  output logic [ADDR_WIDTH-1:0] S_ARADDR,
  output logic [3:0]            S_ARLEN,
  output logic [2:0]            S_ARSIZE,
  output logic [1:0]            S_ARBURST,
  output logic [SID_WIDTH-1:0]  S_ARID,
  input  logic                  S_ARREADY,
  input  logic                  S_RVALID,
  input  logic [DATA_WIDTH-1:0] S_RDATA,
  input  logic [SID_WIDTH-1:0]  S_RID,
  input  logic [1:0]            S_RRESP,
  input  logic                  S_RLAST,
  output logic                  S_RREADY
);

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;
  logic      wr_grant, wr_load, wr_adv, wr_ptr_unused;
  logic      rd_grant, rd_load, rd_adv, rd_ptr_unused;
  logic      unused_id_msb;

  rr_arb2 u_wr_arb (
    .clk     (ACLK),
    .resetn  (ARESETN),
    .req     ({M1_AWVALID, M0_AWVALID}),
    .load    (wr_load),
    .advance (wr_adv),
    .grant   (wr_grant),
    .pointer (wr_ptr_unused)
  );

  rr_arb2 u_rd_arb (
    .clk     (ACLK),
    .resetn  (ARESETN),
    .req     ({M1_ARVALID, M0_ARVALID}),
    .load    (rd_load),
    .advance (rd_adv),
    .grant   (rd_grant),
    .pointer (rd_ptr_unused)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  // Response routing trusts the latched grant, never the ID MSB returned by the bridge.
  assign unused_id_msb = S_BID[MID_WIDTH] ^ S_RID[MID_WIDTH];
  assign M0_BID   = S_BID[MID_WIDTH-1:0];
  assign M1_BID   = S_BID[MID_WIDTH-1:0];
  assign M0_BRESP = S_BRESP;
  assign M1_BRESP = S_BRESP;
  assign M0_RID   = S_RID[MID_WIDTH-1:0];
  assign M1_RID   = S_RID[MID_WIDTH-1:0];
  assign M0_RDATA = S_RDATA;
  assign M1_RDATA = S_RDATA;
  assign M0_RRESP = S_RRESP;
  assign M1_RRESP = S_RRESP;
  assign M0_RLAST = S_RLAST;
  assign M1_RLAST = S_RLAST;

  always_comb begin
    wr_next    = wr_state;
    wr_load    = 1'b0;
    wr_adv     = 1'b0;
    S_AWVALID  = 1'b0;
    S_AWADDR   = '0;
    S_AWLEN    = '0;
    S_AWSIZE   = '0;
    S_AWBURST  = '0;
    S_AWID     = '0;
    S_WVALID   = 1'b0;
    S_WDATA    = '0;
    S_WSTRB    = '0;
    S_WLAST    = 1'b0;
    S_BREADY   = 1'b0;
    M0_AWREADY = 1'b0;
    M1_AWREADY = 1'b0;
    M0_WREADY  = 1'b0;
    M1_WREADY  = 1'b0;
    M0_BVALID  = 1'b0;
    M1_BVALID  = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (M0_AWVALID || M1_AWVALID) begin
          wr_load = 1'b1;
          wr_next = WR_ADDR;
        end
      end
      WR_ADDR: begin
        S_AWVALID  = wr_grant ? M1_AWVALID : M0_AWVALID;
        S_AWADDR   = wr_grant ? M1_AWADDR  : M0_AWADDR;
        S_AWLEN    = wr_grant ? M1_AWLEN   : M0_AWLEN;
        S_AWSIZE   = wr_grant ? M1_AWSIZE  : M0_AWSIZE;
        S_AWBURST  = wr_grant ? M1_AWBURST : M0_AWBURST;
        S_AWID     = {wr_grant, (wr_grant ? M1_AWID : M0_AWID)};
        M0_AWREADY = (wr_grant == ARB_M0) & S_AWREADY;
        M1_AWREADY = (wr_grant == ARB_M1) & S_AWREADY;
        if (S_AWVALID && S_AWREADY) begin
          wr_next = WR_DATA;
        end
      end
      WR_DATA: begin
        S_WVALID  = wr_grant ? M1_WVALID : M0_WVALID;
        S_WDATA   = wr_grant ? M1_WDATA  : M0_WDATA;
        S_WSTRB   = wr_grant ? M1_WSTRB  : M0_WSTRB;
        S_WLAST   = wr_grant ? M1_WLAST  : M0_WLAST;
        M0_WREADY = (wr_grant == ARB_M0) & S_WREADY;
        M1_WREADY = (wr_grant == ARB_M1) & S_WREADY;
        if (S_WVALID && S_WREADY && S_WLAST) begin
          wr_next = WR_RESP;
        end
      end
      WR_RESP: begin
        S_BREADY  = wr_grant ? M1_BREADY : M0_BREADY;
        M0_BVALID = (wr_grant == ARB_M0) & S_BVALID;
        M1_BVALID = (wr_grant == ARB_M1) & S_BVALID;
        if (S_BVALID && S_BREADY) begin
          wr_adv  = 1'b1;
          wr_next = WR_IDLE;
        end
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_next    = rd_state;
    rd_load    = 1'b0;
    rd_adv     = 1'b0;
    S_ARVALID  = 1'b0;
    S_ARADDR   = '0;
    S_ARLEN    = '0;
    S_ARSIZE   = '0;
    S_ARBURST  = '0;
    S_ARID     = '0;
    S_RREADY   = 1'b0;
    M0_ARREADY = 1'b0;
    M1_ARREADY = 1'b0;
    M0_RVALID  = 1'b0;
    M1_RVALID  = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        if (M0_ARVALID || M1_ARVALID) begin
          rd_load = 1'b1;
          rd_next = RD_ADDR;
        end
      end
      RD_ADDR: begin
        S_ARVALID  = rd_grant ? M1_ARVALID : M0_ARVALID;
        S_ARADDR   = rd_grant ? M1_ARADDR  : M0_ARADDR;
        S_ARLEN    = rd_grant ? M1_ARLEN   : M0_ARLEN;
        S_ARSIZE   = rd_grant ? M1_ARSIZE  : M0_ARSIZE;
        S_ARBURST  = rd_grant ? M1_ARBURST : M0_ARBURST;
        S_ARID     = {rd_grant, (rd_grant ? M1_ARID : M0_ARID)};
        M0_ARREADY = (rd_grant == ARB_M0) & S_ARREADY;
        M1_ARREADY = (rd_grant == ARB_M1) & S_ARREADY;
        if (S_ARVALID && S_ARREADY) begin
          rd_next = RD_DATA;
        end
      end
      RD_DATA: begin
        S_RREADY  = rd_grant ? M1_RREADY : M0_RREADY;
        M0_RVALID = (rd_grant == ARB_M0) & S_RVALID;
        M1_RVALID = (rd_grant == ARB_M1) & S_RVALID;
        if (S_RVALID && S_RREADY && S_RLAST) begin
          rd_adv  = 1'b1;
          rd_next = RD_IDLE;
        end
      end
      default: rd_next = RD_IDLE;
    endcase
  end

endmodule
